// File: rtl/time_rd_if.sv
// Time-stream, memory-read and sample-stream signals of time_rd grouped as one bundle.
// slave is the time_rd side; master is the controller/memory/sink side.
interface time_rd_if #(
    parameter int B = 8,
    parameter int N = 10,
    parameter int W = 16
);
    logic         sync_i;
    logic         valid_i;
    logic [B-1:0] t_i;
    logic [N-1:0] ADDR_REG;
    logic         mem_en;
    logic [N-1:0] mem_addr;
    logic [W-1:0] mem_dout;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_last;
    logic         done;
    logic         busy;
    logic         err;

    modport slave (
        input  sync_i, valid_i, t_i, ADDR_REG, mem_dout,
        output mem_en, mem_addr, dout, dout_valid, dout_last, done, busy, err
    );

    modport master (
        output sync_i, valid_i, t_i, ADDR_REG, mem_dout,
        input  mem_en, mem_addr, dout, dout_valid, dout_last, done, busy, err
    );
endinterface

// File: rtl/time_rd.sv
// Time-index consumer: each new t reads the table at base+t; samples come out as pulses. TIME_RD_CHECK_EN adds the continuity checker.
// Latency: t -> mem_en 1 cycle, -> dout_valid RD_LAT+2 cycles; done RD_LAT+2 cycles after valid_i falls.
// No backpressure: one read per cycle, sample pulses cannot be stalled.
module time_rd #(
    parameter int B      = 8,
    parameter int N      = 10,
    parameter int W      = 16,
    parameter int RD_LAT = 2
) (
    input  logic     clk,
    input  logic     rst,
    time_rd_if.slave bus
);
    localparam int             TMAX_I = (1 << (B - 1)) - 1;
    localparam logic [B-1:0]   T_MAX  = TMAX_I[B-1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state;
    logic [N-1:0]  base;
    logic [N-1:0]  addr_q;
    logic [B-1:0]  t_prev;
    logic [3:0]    drain_cnt;
    logic [RD_LAT:0] vld_pipe;
    logic [RD_LAT:0] lst_pipe;
    logic [W-1:0]  dout_q;
    logic          dout_vld_q;
    logic          dout_lst_q;
    logic          done_q;
    logic          busy_q;
    logic          err_q;
    logic          issue;

    // sync_i wins over valid_i; repeated t (controller wait cycles) issues nothing
    always_comb begin
        issue = 1'b0;
        if (!bus.sync_i && bus.valid_i)
            issue = (state == S_ARMED) || ((state == S_RUN) && (bus.t_i != t_prev));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            base      <= '0;
            t_prev    <= '0;
            drain_cnt <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state != S_IDLE);
            if (issue)
                t_prev <= bus.t_i;
            case (state)
                S_IDLE: begin
                    if (bus.sync_i) begin
                        base  <= bus.ADDR_REG;
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (bus.sync_i)
                        base <= bus.ADDR_REG;
                    else if (bus.valid_i)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (bus.sync_i) begin
                        base  <= bus.ADDR_REG;
                        state <= S_ARMED;
                    end else if (!bus.valid_i) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end
                end
                default: begin
                    // drain lasts RD_LAT+1 cycles so the last sample is out before done
                    if (bus.sync_i) begin
                        base  <= bus.ADDR_REG;
                        state <= S_ARMED;
                    end else if (drain_cnt == 4'(RD_LAT)) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // read pipeline: stage 0 is mem_en, stage RD_LAT lines up with valid mem_dout
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            lst_pipe   <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_lst_q <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[RD_LAT-1:0], issue};
            lst_pipe   <= {lst_pipe[RD_LAT-1:0], issue && (bus.t_i == T_MAX)};
            if (issue)
                addr_q <= base + N'(bus.t_i);
            dout_vld_q <= vld_pipe[RD_LAT];
            dout_lst_q <= lst_pipe[RD_LAT];
            if (vld_pipe[RD_LAT])
                dout_q <= bus.mem_dout;
        end
    end

`ifdef TIME_RD_CHECK_EN
    logic [B-1:0] t_next;
    logic         seq_bad;

    assign t_next  = t_prev + B'(1);
    assign seq_bad = (state == S_ARMED) ? (bus.t_i != '0) : (bus.t_i != t_next);

    always_ff @(posedge clk) begin
        if (rst || bus.sync_i)
            err_q <= 1'b0;
        else if (issue && seq_bad)
            err_q <= 1'b1;
    end
`else
    assign err_q = 1'b0;
`endif

    assign bus.mem_en     = vld_pipe[0];
    assign bus.mem_addr   = addr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_vld_q;
    assign bus.dout_last  = dout_lst_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_time_rd.sv
// Randomized bench for time_rd: expected reads, samples, done, busy and err are scheduled per cycle from the stimulus.
// A latency-RD_LAT memory model with random contents sits on the read port.
module tb_time_rd;
    localparam int B      = 8;
    localparam int N      = 10;
    localparam int W      = 16;
    localparam int RD_LAT = 2;
    localparam int T_MAX  = (1 << (B - 1)) - 1;
`ifdef TIME_RD_CHECK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    time_rd_if #(.B(B), .N(N), .W(W)) bus();
    time_rd #(.B(B), .N(N), .W(W), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    // memory: data for the address presented RD_LAT cycles earlier
    logic [W-1:0] mem [1 << N];
    logic [N-1:0] ad_q [RD_LAT];
    always @(posedge clk) begin
        ad_q[0] <= bus.mem_addr;
        for (int i = 1; i < RD_LAT; i++) ad_q[i] <= ad_q[i-1];
    end
    assign bus.mem_dout = mem[ad_q[RD_LAT-1]];

    typedef struct { logic [31:0] v; int ep; } ev_t;
    ev_t exp_en[int], exp_dv[int], exp_done[int], ev_busy[int], ev_err[int], ev_dout[int];

    int cyc = 0, checks = 0, errors = 0, epoch = 0, rst_cyc = -1;
    logic [31:0] cur_busy = 0, cur_err = 0, cur_dout = 0;
    bit mon_on = 1'b0;
    bit m_run, m_first;
    logic [N-1:0] m_base;
    logic [B-1:0] m_tprev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // an expectation scheduled before a reset for a cycle after it never happens
    function automatic bit live(input ev_t e);
        return !(e.ep < epoch && cyc > rst_cyc);
    endfunction

    always @(negedge clk) begin : mon
        bit en_x, dv_x, dn_x;
        if (mon_on) begin
            en_x = exp_en.exists(cyc) && live(exp_en[cyc]);
            dv_x = exp_dv.exists(cyc) && live(exp_dv[cyc]);
            dn_x = exp_done.exists(cyc) && live(exp_done[cyc]);
            if (ev_busy.exists(cyc) && live(ev_busy[cyc])) cur_busy = ev_busy[cyc].v;
            if (ev_err.exists(cyc) && live(ev_err[cyc]))   cur_err  = ev_err[cyc].v;
            if (ev_dout.exists(cyc) && live(ev_dout[cyc])) cur_dout = ev_dout[cyc].v;
            if (dv_x) cur_dout = {16'd0, exp_dv[cyc].v[15:0]};
            chk("mem_en", 32'(bus.mem_en), 32'(en_x));
            if (en_x) chk("mem_addr", 32'(bus.mem_addr), exp_en[cyc].v);
            chk("dout_valid", 32'(bus.dout_valid), 32'(dv_x));
            chk("dout_last", 32'(bus.dout_last), dv_x ? 32'(exp_dv[cyc].v[16]) : 32'd0);
            chk("dout", 32'(bus.dout), cur_dout);
            chk("done", 32'(bus.done), 32'(dn_x));
            chk("busy", 32'(bus.busy), cur_busy);
            chk("err", 32'(bus.err), cur_err);
        end
    end

    task automatic step(input bit s, input bit v, input logic [B-1:0] t, input logic [N-1:0] a, input bit r);
        @(posedge clk); #1;
        bus.sync_i = s; bus.valid_i = v; bus.t_i = t; bus.ADDR_REG = a; rst = r;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, B'($urandom), N'($urandom), 1'b0);
    endtask

    task automatic drive_sync(input logic [N-1:0] a);
        step(1'b1, 1'b0, B'($urandom), a, 1'b0);
        m_base = a; m_first = 1'b1; m_run = 1'b0;
        ev_busy[cyc+2] = '{v: 32'd1, ep: epoch};
        ev_err[cyc+1]  = '{v: 32'd0, ep: epoch};
    endtask

    task automatic drive_t(input logic [B-1:0] t);
        int addr;
        step(1'b0, 1'b1, t, N'($urandom), 1'b0);
        if (m_first || t != m_tprev) begin
            addr = (int'(m_base) + int'(t)) % (1 << N);
            exp_en[cyc+1] = '{v: 32'(addr), ep: epoch};
            exp_dv[cyc+2+RD_LAT] = '{v: 32'({(int'(t) == T_MAX), mem[addr]}), ep: epoch};
            if (CHK_ON && (m_first ? (t != 0) : (int'(t) != (int'(m_tprev) + 1) % (1 << B))))
                ev_err[cyc+1] = '{v: 32'd1, ep: epoch};
            m_first = 1'b0; m_tprev = t; m_run = 1'b1;
        end
    endtask

    task automatic drive_end();
        step(1'b0, 1'b0, B'($urandom), N'($urandom), 1'b0);
        if (m_run) begin
            exp_done[cyc+RD_LAT+2] = '{v: 32'd1, ep: epoch};
            ev_busy[cyc+RD_LAT+3]  = '{v: 32'd0, ep: epoch};
        end
        m_run = 1'b0;
        idle(RD_LAT + 3);
    endtask

    task automatic drive_reset();
        step(1'b0, 1'b0, '0, '0, 1'b1);
        epoch++; rst_cyc = cyc;
        ev_busy[cyc+1] = '{v: 32'd0, ep: epoch};
        ev_err[cyc+1]  = '{v: 32'd0, ep: epoch};
        ev_dout[cyc+1] = '{v: 32'd0, ep: epoch};
        m_run = 1'b0;
        idle(1);
        @(negedge clk);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    endtask

    initial begin
        int len, hold;
        logic [B-1:0] tv;
        bus.sync_i = 1'b0; bus.valid_i = 1'b0; bus.t_i = '0; bus.ADDR_REG = '0; rst = 1'b1;
        foreach (mem[i]) mem[i] = W'($urandom);
        repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("reset_mem_en", 32'(bus.mem_en), 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_dout", 32'(bus.dout), 32'd0);
        chk("reset_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("reset_dout_last", 32'(bus.dout_last), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        mon_on = 1'b1;

        // full ramp 0..T_MAX
        drive_sync(10'h100);
        for (int i = 0; i <= T_MAX; i++) drive_t(B'(i));
        drive_end();

        // each t held three cycles
        drive_sync(10'h2A0);
        for (int i = 0; i < 20; i++) repeat (3) drive_t(B'(i));
        drive_end();

        // address wraps past the top of memory
        drive_sync(10'h3F0);
        for (int i = 0; i < 32; i++) drive_t(B'(i));
        drive_end();

        // skipped index, then a sync clears err
        drive_sync(10'h040);
        drive_t(8'd0); drive_t(8'd1); drive_t(8'd3); drive_t(8'd4);
        drive_end();
        @(negedge clk);
        chk("err_sticky", 32'(bus.err), 32'(CHK_ON));
        drive_sync(10'h040);
        drive_t(8'd0);
        drive_end();

        // re-sync mid-run with a new base
        drive_sync(10'h100);
        for (int i = 0; i < 10; i++) drive_t(B'(i));
        drive_sync(10'h200);
        for (int i = 0; i < 10; i++) drive_t(B'(i));
        drive_end();

        // reset with reads in flight
        drive_sync(10'h155);
        for (int i = 0; i < 6; i++) drive_t(B'(i));
        drive_reset();
        idle(8);

        // random bursts: random base, length, hold, skips, start, and ending by drain or re-sync
        for (int b = 0; b < 25; b++) begin
            drive_sync(N'($urandom));
            len  = $urandom_range(1, 40);
            hold = $urandom_range(1, 3);
            tv   = ($urandom_range(0, 3) == 0) ? B'($urandom_range(0, 255)) : '0;
            for (int i = 0; i < len; i++) begin
                repeat (hold) drive_t(tv);
                tv = tv + (($urandom_range(0, 19) == 0) ? B'(2) : B'(1));
            end
            if (b == 24 || $urandom_range(0, 3) != 0) drive_end();
        end

        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
